// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the execute-stage controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SHL  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_MFLO = 4'd14;
  localparam logic [3:0] OP_SUB  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  // Branches are evaluated as a subtract; the zero flag decides the outcome.
  function automatic logic [3:0] alu_map_op(input logic [3:0] op);
    return ((op == OP_BEQ) || (op == OP_BNE)) ? OP_SUB : op;
  endfunction

endpackage

// File: rtl/mul16_iter.sv
// Iterative unsigned 16x16 shift-add multiplier with a 32-bit product.
// Latency: start at edge E0, done (with product valid combinationally) during the 16th busy cycle.
// Backpressure: none; start is only honoured while idle, product is valid only while done is high.
module mul16_iter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [4:0]         r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_sum;

  // Partial sum for this iteration; on the last iteration it is the full product.
  assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == 5'd15);
  assign o_product = w_sum;

  // One shift-add step per cycle: multiplicand moves left, multiplier moves right.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd15) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: sequences the ALU, owns HI/LO, runs iterative multiply.
// Latency: 1 cycle for ALU/branch/mfhi/mflo ops, 16 cycles for multiply.
// Backpressure: in_ready low while busy or while an unconsumed result is held; outputs hold until out_ready.
module alu_exec_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_taken
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0]   w_hilo;

  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (in_opcode == OP_MUL);
  assign w_hilo      = (r_op == OP_MFHI) ? r_hi : r_lo;

  // The ALU sees the operand registers, which only change when a non-multiply op is accepted.
  assign alu_opcode = alu_map_op(r_op);
  assign alu_a      = r_a;
  assign alu_b      = r_b;

  mul16_iter u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and accept logic; a held result blocks new work unless it is being consumed now.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = (!out_valid || out_ready) && !w_mul_busy;
        if (in_valid && in_ready)
          w_state_nxt = (in_opcode == OP_MUL) ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_IDLE;
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture for the single-cycle ALU ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept && (in_opcode != OP_MUL)) begin
      r_op <= in_opcode;
      r_a  <= in_a;
      r_b  <= in_b;
    end
  end

  // Result/flag capture, HI/LO update, and out_valid handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_ovf    <= 1'b0;
      out_taken  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else if (r_state == ST_EXEC) begin
      out_valid <= 1'b1;
      out_taken <= 1'b0;
      if ((r_op == OP_BEQ) || (r_op == OP_BNE)) begin
        out_result <= '0;
        out_zero   <= alu_zero;
        out_neg    <= 1'b0;
        out_ovf    <= 1'b0;
        out_taken  <= (r_op == OP_BEQ) ? alu_zero : !alu_zero;
      end else if ((r_op == OP_MFHI) || (r_op == OP_MFLO)) begin
        out_result <= w_hilo;
        out_zero   <= (w_hilo == '0);
        out_neg    <= w_hilo[WIDTH-1];
        out_ovf    <= 1'b0;
      end else begin
        out_result <= alu_out;
        out_zero   <= alu_zero;
        out_neg    <= alu_out[WIDTH-1];
        out_ovf    <= alu_ovf;
      end
    end else if ((r_state == ST_MUL) && w_mul_done) begin
      out_valid  <= 1'b1;
      r_hi       <= w_mul_product[2*WIDTH-1:WIDTH];
      r_lo       <= w_mul_product[WIDTH-1:0];
      out_result <= w_mul_product[WIDTH-1:0];
      out_zero   <= (w_mul_product == '0);
      out_neg    <= w_mul_product[WIDTH-1];
      out_ovf    <= (w_mul_product[2*WIDTH-1:WIDTH] != '0);
      out_taken  <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: behavioural ALU, cycle-level reference model, directed vectors.
// Latency: checks 1-cycle ALU ops and 16-cycle multiply.
// Backpressure: exercises held results with out_ready low and same-cycle consume/accept.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a, in_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_zero, alu_ovf;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_zero, out_neg, out_ovf, out_taken;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf), .out_taken(out_taken)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  // Combinational ALU the controller drives; ovf is carry (add) or borrow (sub).
  function automatic logic [16:0] bench_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd15:   return {1'b0, a} - {1'b0, b};
      4'd1:    return {1'b0, a << b[3:0]};
      4'd2:    return {1'b0, a >> b[3:0]};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  logic [16:0] alu_r;
  always_comb begin
    alu_r    = bench_alu(alu_opcode, alu_a, alu_b);
    alu_out  = alu_r[15:0];
    alu_ovf  = alu_r[16];
    alu_zero = (alu_r[15:0] == 16'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a, b, res, hi, lo;
    logic        z, n, o, t, mul;
  } exp_t;

  function automatic exp_t model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] hi, input logic [15:0] lo);
    exp_t e;
    int unsigned ua, ub, p;
    e = '0; e.op = op; e.a = a; e.b = b;
    ua = a; ub = b; p = 0;
    case (op)
      4'd0:  begin p = ua + ub; e.res = p[15:0]; e.o = (p > 32'hFFFF); end
      4'd15: begin e.res = a - b; e.o = (ua < ub); end
      4'd1:  e.res = a << b[3:0];
      4'd2:  e.res = a >> b[3:0];
      4'd3:  e.res = a | b;
      4'd4:  e.res = a & b;
      4'd10: begin e.z = (a == b); e.t = (a == b); end
      4'd11: begin e.z = (a == b); e.t = (a != b); end
      4'd12: e.res = hi;
      4'd14: e.res = lo;
      4'd13: begin p = ua * ub; e.mul = 1'b1; e.hi = p[31:16]; e.lo = p[15:0];
                   e.res = p[15:0]; e.o = (p[31:16] != 16'h0); end
      default: e.res = a ^ b;
    endcase
    if (op != 4'd10 && op != 4'd11) begin
      e.z = (e.res == 16'h0);
      e.n = e.res[15];
    end
    if (op == 4'd13) e.z = (p == 0);
    return e;
  endfunction

  int          m_pend = 0;
  logic        m_vld = 1'b0;
  exp_t        m_stage = '0;
  exp_t        m_out = '0;
  logic [15:0] m_hi = 16'h0, m_lo = 16'h0;
  logic        m_rdy;

  assign m_rdy = (m_pend == 0) && (!m_vld || out_ready);

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 0; m_vld <= 1'b0; m_out <= '0; m_hi <= 16'h0; m_lo <= 16'h0;
    end else begin
      if (m_pend == 1) begin
        m_vld <= 1'b1;
        m_out <= m_stage;
        if (m_stage.mul) begin m_hi <= m_stage.hi; m_lo <= m_stage.lo; end
      end else if (m_vld && out_ready) begin
        m_vld <= 1'b0;
      end
      if (in_valid && m_rdy) begin
        m_stage <= model_op(in_opcode, in_a, in_b, m_hi, m_lo);
        m_pend  <= (in_opcode == 4'd13) ? 16 : 1;
      end else if (m_pend > 0) begin
        m_pend <= m_pend - 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_vld);
      chk("out_result", out_result, m_out.res);
      chk("out_zero", out_zero, m_out.z);
      chk("out_neg", out_neg, m_out.n);
      chk("out_ovf", out_ovf, m_out.o);
      chk("out_taken", out_taken, m_out.t);
      if (m_pend == 1 && !m_stage.mul) begin
        chk("alu_opcode", alu_opcode, (m_stage.op == 4'd10 || m_stage.op == 4'd11) ? 4'd15 : m_stage.op);
        chk("alu_a", alu_a, m_stage.a);
        chk("alu_b", alu_b, m_stage.b);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] r_res;
  logic        r_z, r_n, r_o, r_t;
  int          r_lat;

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    #1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(negedge clk); #1; cnt++;
    end
    chk("accept_in_time", (cnt < 100), 1);
    @(negedge clk);
    in_valid = 1'b0;
    r_lat = 0;
    while (!out_valid && r_lat < 40) begin
      @(negedge clk); r_lat++;
    end
    chk("result_in_time", (r_lat < 40), 1);
    r_res = out_result; r_z = out_zero; r_n = out_neg; r_o = out_ovf; r_t = out_taken;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = 4'd0; in_a = 16'h0; in_b = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    rst = 1'b0;

    run_op(4'd0, 16'h7FFF, 16'h0001);
    chk("add_res", r_res, 16'h8000); chk("add_neg", r_n, 1); chk("add_zero", r_z, 0);
    chk("add_ovf", r_o, 0); chk("add_lat", r_lat, 1);

    run_op(4'd15, 16'd3, 16'd5);
    chk("sub_res", r_res, 16'hFFFE); chk("sub_neg", r_n, 1); chk("sub_ovf", r_o, 1);

    run_op(4'd13, 16'h1234, 16'h5678);
    chk("mul_res", r_res, 16'h0060); chk("mul_ovf", r_o, 1); chk("mul_lat", r_lat, 16);
    run_op(4'd12, 16'h0, 16'h0);
    chk("mfhi_res", r_res, 16'h0626);
    run_op(4'd14, 16'h0, 16'h0);
    chk("mflo_res", r_res, 16'h0060);

    run_op(4'd10, 16'd5, 16'd5);
    chk("beq_taken", r_t, 1); chk("beq_zero", r_z, 1); chk("beq_res", r_res, 0);
    run_op(4'd11, 16'd5, 16'd6);
    chk("bne_taken", r_t, 1);
    run_op(4'd11, 16'd7, 16'd7);
    chk("bne_not_taken", r_t, 0);

    run_op(4'd1, 16'h0003, 16'd4);
    chk("shl_res", r_res, 16'h0030);
    run_op(4'd7, 16'hFF00, 16'h0FF0);
    chk("op7_res", r_res, 16'hF0F0);
    run_op(4'd13, 16'h0100, 16'h0100);
    chk("mul_hi_only_zero", r_z, 0); chk("mul_hi_only_res", r_res, 0);
    run_op(4'd13, 16'h0000, 16'h1234);
    chk("mul0_zero", r_z, 1); chk("mul0_ovf", r_o, 0);

    // Backpressure: result held with out_ready low, then consume and accept together.
    @(negedge clk);
    out_ready = 1'b0;
    run_op(4'd4, 16'hF0F0, 16'h0FF0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_res", out_result, 16'h00F0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 4'd0; in_a = 16'd1; in_b = 16'd2;
    #1;
    chk("bp_same_cycle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_res", out_result, 16'd3);

    // Reset eight cycles into a multiply.
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 4'd13; in_a = 16'h1234; in_b = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmul_valid", out_valid, 0);
    chk("rstmul_res", out_result, 0);
    chk("rstmul_ready", in_ready, 1);
    chk("rstmul_ovf", out_ovf, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rstmul_no_pulse", out_valid, 0);
    end
    run_op(4'd12, 16'h0, 16'h0);
    chk("rstmul_mfhi", r_res, 16'h0000);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
